mem_store_buffer: RTL and testbench

MEM_STORE_BUFFER -- requirements
Module: mem_store_buffer

---
 rtl/mem_store_buffer.sv | 152 +++++++++++++++
 tb/tb_mem_store_buffer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_store_buffer.sv
// Store buffer between the exec/mem latch and data memory: stores are queued and
// drained in the background, loads forward from the youngest matching entry.
module mem_store_buffer #(
  parameter int DW       = 32,
  parameter int SB_DEPTH = 4,
  parameter int WSEL_W   = 5
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      en,
  input  logic                      in_ren,
  input  logic                      in_wen,
  input  logic [DW-1:0]             in_addr,
  input  logic [DW-1:0]             in_wdata,
  input  logic [WSEL_W-1:0]         in_wsel,
  input  logic                      in_halt,
  input  logic                      dhit,
  input  logic [DW-1:0]             dmemload,
  output logic                      dmemREN,
  output logic                      dmemWEN,
  output logic [DW-1:0]             dmemaddr,
  output logic [DW-1:0]             dmemstore,
  output logic                      data_stall,
  output logic [$clog2(SB_DEPTH):0] sb_count,
  output logic [DW-1:0]             out_load,
  output logic [WSEL_W-1:0]         out_wsel,
  output logic                      out_halt
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DW-1:0]     addr_mem [SB_DEPTH];
  logic [DW-1:0]     data_mem [SB_DEPTH];
  logic [DW-1:0]     out_load_q;
  logic [WSEL_W-1:0] out_wsel_q;
  logic              out_halt_q;

  logic              full, is_load, load_hit, load_miss, push, pop;
  logic              fwd_hit;
  logic [DW-1:0]     fwd_data;
  logic [SB_DEPTH-1:0] age_match;
  logic [DW-1:0]     age_data [SB_DEPTH];

  assign full      = (count_q == CW'(SB_DEPTH));
  assign is_load   = in_ren & ~in_wen;
  assign push      = en & in_wen & ~full;
  assign pop       = (state_q == DRAIN) & dhit;

  // Entries viewed oldest (gi = 0) to youngest; the head entry stays visible while draining.
  generate
    for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_age
      logic [PW-1:0] slot;
      assign slot          = head_q + PW'(gi);
      assign age_match[gi] = (CW'(gi) < count_q) && (addr_mem[slot] == in_addr);
      assign age_data[gi]  = data_mem[slot];
    end
  endgenerate

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (age_match[i]) begin
        fwd_hit  = 1'b1;
        fwd_data = age_data[i];
      end
    end
  end

  assign load_hit  = is_load & fwd_hit;
  assign load_miss = is_load & ~fwd_hit;

  assign head_d  = pop  ? head_q + PW'(1) : head_q;
  assign tail_d  = push ? tail_q + PW'(1) : tail_q;
  assign count_d = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      out_load_q <= '0;
      out_wsel_q <= '0;
      out_halt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (en) begin
        out_load_q <= load_hit ? fwd_data : dmemload;
        out_wsel_q <= in_wsel;
        out_halt_q <= in_halt;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      addr_mem[tail_q] <= in_addr;
      data_mem[tail_q] <= in_wdata;
    end
  end

  // A missing load holds off the next drain so the read port is never contended.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (count_q != '0 && !load_miss) state_d = DRAIN;
      DRAIN:   if (dhit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dmemREN    = 1'b0;
    dmemWEN    = 1'b0;
    dmemaddr   = in_addr;
    dmemstore  = '0;
    data_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_miss) begin
          dmemREN    = 1'b1;
          data_stall = ~dhit;
        end
      end
      DRAIN: begin
        dmemWEN   = 1'b1;
        dmemaddr  = addr_mem[head_q];
        dmemstore = data_mem[head_q];
        if (load_miss) data_stall = 1'b1;
      end
      default: ;
    endcase
    if (in_wen && full) data_stall = 1'b1;
    if (in_halt && (count_q != '0 || state_q == DRAIN)) data_stall = 1'b1;
  end

  assign sb_count = count_q;
  assign out_load = out_load_q;
  assign out_wsel = out_wsel_q;
  assign out_halt = out_halt_q;

endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed bench for mem_store_buffer: enqueue/drain, forwarding, full stall,
// load-vs-drain arbitration, halt drain and asynchronous reset.
module tb_mem_store_buffer;

  localparam int DW       = 32;
  localparam int SB_DEPTH = 4;
  localparam int WSEL_W   = 5;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              en, in_ren, in_wen, in_halt, dhit;
  logic [DW-1:0]     in_addr, in_wdata, dmemload;
  logic [WSEL_W-1:0] in_wsel;
  logic              dmemREN, dmemWEN, data_stall, out_halt;
  logic [DW-1:0]     dmemaddr, dmemstore, out_load;
  logic [$clog2(SB_DEPTH):0] sb_count;
  logic [WSEL_W-1:0] out_wsel;

  int checks   = 0;
  int failures = 0;

  mem_store_buffer #(.DW(DW), .SB_DEPTH(SB_DEPTH), .WSEL_W(WSEL_W)) dut (
    .CLK(CLK), .nRST(nRST), .en(en), .in_ren(in_ren), .in_wen(in_wen),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_wsel(in_wsel), .in_halt(in_halt),
    .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .data_stall(data_stall),
    .sb_count(sb_count), .out_load(out_load), .out_wsel(out_wsel), .out_halt(out_halt)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_in();
    en = 1'b0; in_ren = 1'b0; in_wen = 1'b0; in_halt = 1'b0; dhit = 1'b0;
    in_addr = '0; in_wdata = '0; in_wsel = '0; dmemload = '0;
  endtask

  task automatic store(input logic [DW-1:0] a, input logic [DW-1:0] d);
    clear_in();
    en = 1'b1; in_wen = 1'b1; in_addr = a; in_wdata = d;
    step();
  endtask

  // Hold dhit until the buffer is empty, bounded.
  task automatic drain_all();
    clear_in();
    dhit = 1'b1;
    for (int i = 0; i < 30; i++) begin
      settle();
      if (sb_count == 0) break;
      step();
    end
    dhit = 1'b0;
    settle();
    check_eq("drain_empty", sb_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    nRST = 1'b0;
    clear_in();
    in_addr = 32'h55;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_count", sb_count, 0);
    check_eq("rst_wen", dmemWEN, 0);
    check_eq("rst_ren", dmemREN, 0);
    check_eq("rst_addr", dmemaddr, 32'h55);
    check_eq("rst_load", out_load, 0);
    check_eq("rst_wsel", out_wsel, 0);
    check_eq("rst_halt", out_halt, 0);
    nRST = 1'b1;
    step();
    $display("txn reset done checks=%0d", checks);

    // Single store: enqueue, then drain one cycle later
    clear_in();
    en = 1'b1; in_wen = 1'b1; in_addr = 32'h100; in_wdata = 32'hAAAA;
    settle();
    check_eq("st_stall", data_stall, 0);
    check_eq("st_nowen", dmemWEN, 0);
    step();
    check_eq("st_count1", sb_count, 1);
    clear_in();
    settle();
    check_eq("st_idle_wen", dmemWEN, 0);
    step();
    check_eq("st_drain_wen", dmemWEN, 1);
    check_eq("st_drain_addr", dmemaddr, 32'h100);
    check_eq("st_drain_data", dmemstore, 32'hAAAA);
    check_eq("st_drain_ren", dmemREN, 0);
    step();
    check_eq("st_hold_addr", dmemaddr, 32'h100);
    dhit = 1'b1;
    step();
    dhit = 1'b0;
    settle();
    check_eq("st_pop_count", sb_count, 0);
    check_eq("st_pop_wen", dmemWEN, 0);
    $display("txn enqueue_drain done checks=%0d", checks);

    // Youngest match wins over the entry being drained
    store(32'h40, 32'h1);
    store(32'h40, 32'h2);
    clear_in();
    en = 1'b1; in_ren = 1'b1; in_addr = 32'h40; in_wsel = 5'd7; dmemload = 32'hBAD;
    settle();
    check_eq("fwd_stall", data_stall, 0);
    check_eq("fwd_ren", dmemREN, 0);
    step();
    check_eq("fwd_load", out_load, 32'h2);
    check_eq("fwd_wsel", out_wsel, 7);
    drain_all();
    $display("txn youngest_forward done checks=%0d", checks);

    // Full buffer: fifth store stalls until a pop has completed
    for (int i = 0; i < 4; i++) store(32'h10 + i, 32'hD0 + i);
    check_eq("full_count", sb_count, 4);
    clear_in();
    en = 1'b1; in_wen = 1'b1; in_addr = 32'h14; in_wdata = 32'hD4;
    settle();
    check_eq("full_stall", data_stall, 1);
    check_eq("full_head", dmemaddr, 32'h10);
    step();
    check_eq("full_stall2", sb_count, 4);
    dhit = 1'b1;
    settle();
    check_eq("full_pop_stall", data_stall, 1);
    step();
    dhit = 1'b0;
    settle();
    check_eq("full_cnt3", sb_count, 3);
    check_eq("full_release", data_stall, 0);
    step();
    check_eq("full_cnt4", sb_count, 4);
    clear_in();
    settle();
    check_eq("full_next_addr", dmemaddr, 32'h11);
    check_eq("full_next_data", dmemstore, 32'hD1);
    drain_all();
    $display("txn full_buffer done checks=%0d", checks);

    // Missing load while draining waits for the pop, then reads
    store(32'h90, 32'h99);
    clear_in();
    step();
    en = 1'b1; in_ren = 1'b1; in_addr = 32'h80; in_wsel = 5'd3; dmemload = 32'hDEAD0000;
    settle();
    check_eq("lvd_stall", data_stall, 1);
    check_eq("lvd_ren0", dmemREN, 0);
    check_eq("lvd_wen1", dmemWEN, 1);
    step();
    check_eq("lvd_stall2", data_stall, 1);
    dhit = 1'b1;
    settle();
    check_eq("lvd_pop_stall", data_stall, 1);
    step();
    dhit = 1'b0;
    settle();
    check_eq("lvd_ren1", dmemREN, 1);
    check_eq("lvd_wen0", dmemWEN, 0);
    check_eq("lvd_addr", dmemaddr, 32'h80);
    check_eq("lvd_wait", data_stall, 1);
    dhit = 1'b1; dmemload = 32'h12345678;
    settle();
    check_eq("lvd_go", data_stall, 0);
    step();
    check_eq("lvd_load", out_load, 32'h12345678);
    check_eq("lvd_wsel", out_wsel, 3);

    // Load beats a pending drain start in IDLE
    store(32'hA0, 32'h5);
    clear_in();
    in_ren = 1'b1; in_addr = 32'h84;
    settle();
    check_eq("prio_ren", dmemREN, 1);
    check_eq("prio_wen", dmemWEN, 0);
    check_eq("prio_stall", data_stall, 1);
    step();
    check_eq("prio_wen2", dmemWEN, 0);
    check_eq("prio_count", sb_count, 1);
    en = 1'b1; dhit = 1'b1; dmemload = 32'hCAFE;
    settle();
    check_eq("prio_go", data_stall, 0);
    step();
    check_eq("prio_load", out_load, 32'hCAFE);
    drain_all();
    $display("txn load_vs_drain done checks=%0d", checks);

    // Forward from the entry under drain, then halt until empty
    store(32'h200, 32'h1);
    store(32'h204, 32'h2);
    clear_in();
    en = 1'b1; in_ren = 1'b1; in_addr = 32'h200; in_wsel = 5'd9; dmemload = 32'hBAD;
    settle();
    check_eq("drn_fwd_stall", data_stall, 0);
    step();
    check_eq("drn_fwd_load", out_load, 32'h1);
    clear_in();
    in_halt = 1'b1; dhit = 1'b1;
    settle();
    check_eq("halt_stall", data_stall, 1);
    n = 0;
    while (data_stall && n < 20) begin
      step();
      n++;
    end
    check_eq("halt_cycles", n, 3);
    check_eq("halt_count", sb_count, 0);
    check_eq("halt_pre", out_halt, 0);
    dhit = 1'b0; en = 1'b1;
    step();
    check_eq("halt_out", out_halt, 1);
    $display("txn halt done checks=%0d", checks);

    // Read+write together is a store; then reset while draining
    clear_in();
    en = 1'b1; in_ren = 1'b1; in_wen = 1'b1; in_addr = 32'h300; in_wdata = 32'h33;
    in_wsel = 5'h1F; dmemload = 32'h77;
    settle();
    check_eq("rw_ren", dmemREN, 0);
    check_eq("rw_stall", data_stall, 0);
    step();
    check_eq("rw_count", sb_count, 1);
    clear_in();
    step();
    check_eq("rd_wen", dmemWEN, 1);
    #2;
    nRST = 1'b0;
    #1;
    check_eq("rd_wen0", dmemWEN, 0);
    check_eq("rd_count", sb_count, 0);
    check_eq("rd_load", out_load, 0);
    check_eq("rd_wsel", out_wsel, 0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    step();
    check_eq("rd_after_wen", dmemWEN, 0);
    check_eq("rd_after_count", sb_count, 0);
    $display("txn reset_mid_drain done checks=%0d", checks);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
